// File: rtl/fifo_mem_mc_pkg.sv
// fifo_mem_mc_pkg: default geometry and elaboration helpers for the multi-channel FIFO bank
package fifo_mem_mc_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int NUM_CH_DEF = 8;
  localparam int DEPTH_DEF = 256;
  localparam int ADDR_W_DEF = 8;
  localparam int AFULL_TH_DEF = 252;
  localparam int AEMPTY_TH_DEF = 4;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/fifo_mem_mc_sdp_ram.sv
// fifo_sdp_ram: inferred simple dual-port RAM with a registered, enabled read port
module fifo_sdp_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // only the output register is reset; array contents are left undefined
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/fifo_mem_mc.sv
// fifo_mem_mc: bank of independent FIFOs sharing a broadcast write-data bus
module fifo_mem_mc
  import fifo_mem_mc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int AFULL_TH = AFULL_TH_DEF,
  parameter int AEMPTY_TH = AEMPTY_TH_DEF
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic [NUM_CH-1:0]            wr_en,
  input  logic [NUM_CH-1:0]            rd_en,
  input  logic [NUM_CH-1:0]            flush,
  input  logic                         clr_err,
  output logic [DATA_W*NUM_CH-1:0]     rd_data,
  output logic [NUM_CH-1:0]            rd_valid,
  output logic [(ADDR_W+1)*NUM_CH-1:0] count,
  output logic [NUM_CH-1:0]            full,
  output logic [NUM_CH-1:0]            empty,
  output logic [NUM_CH-1:0]            afull,
  output logic [NUM_CH-1:0]            aempty,
  output logic [NUM_CH-1:0]            ovf_err,
  output logic [NUM_CH-1:0]            udf_err
);
  localparam int CW = ADDR_W + 1;
  if (DEPTH != 2**ADDR_W || clog2(DEPTH) != ADDR_W || DEPTH < 4) begin : g_bad_depth
    $fatal(1, "fifo_mem_mc: DEPTH must equal 2**ADDR_W and be at least 4");
  end
  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt, cnt_nx;
    logic full_r, empty_r, afull_r, aempty_r, vld_r, ovf_r, udf_r;
    logic rd_acc, wr_acc, ovf_set, udf_set;
    // a full FIFO still accepts a write when a read frees a slot in the same cycle
    assign rd_acc = rd_en[n] & ~empty_r & ~flush[n];
    assign wr_acc = wr_en[n] & (~full_r | rd_acc) & ~flush[n];
    assign ovf_set = wr_en[n] & ~flush[n] & full_r & ~rd_acc;
    assign udf_set = rd_en[n] & ~flush[n] & empty_r;
    assign cnt_nx = flush[n] ? '0 : cnt + CW'(wr_acc) - CW'(rd_acc);
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt <= '0;
        full_r <= 1'b0;
        empty_r <= 1'b1;
        afull_r <= 1'b0;
        aempty_r <= 1'b1;
        vld_r <= 1'b0;
        ovf_r <= 1'b0;
        udf_r <= 1'b0;
      end else begin
        wr_ptr <= flush[n] ? '0 : wr_ptr + ADDR_W'(wr_acc);
        rd_ptr <= flush[n] ? '0 : rd_ptr + ADDR_W'(rd_acc);
        cnt <= cnt_nx;
        full_r <= cnt_nx == CW'(DEPTH);
        empty_r <= cnt_nx == '0;
        afull_r <= cnt_nx >= CW'(AFULL_TH);
        aempty_r <= cnt_nx <= CW'(AEMPTY_TH);
        vld_r <= rd_acc;
        ovf_r <= ovf_set | (ovf_r & ~clr_err);
        udf_r <= udf_set | (udf_r & ~clr_err);
      end
    fifo_sdp_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
      .clk(clk),
      .reset_n(reset_n),
      .we(wr_acc),
      .waddr(wr_ptr),
      .wdata(wr_data),
      .re(rd_acc),
      .raddr(rd_ptr),
      .rdata(rd_data[DATA_W*n +: DATA_W])
    );
    assign count[CW*n +: CW] = cnt;
    assign full[n] = full_r;
    assign empty[n] = empty_r;
    assign afull[n] = afull_r;
    assign aempty[n] = aempty_r;
    assign rd_valid[n] = vld_r;
    assign ovf_err[n] = ovf_r;
    assign udf_err[n] = udf_r;
  end
endmodule

// File: tb/tb_fifo_mem_mc.sv
// tb_fifo_mem_mc: randomized and directed scoreboard bench against a queue-based FIFO model
module tb_fifo_mem_mc;
  localparam int DW = 16, NC = 8, DEP = 256, AW = 8, AF = 252, AE = 4, CW = AW + 1;
  logic clk = 1'b0, reset_n = 1'b0, clr_err = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [NC-1:0] wr_en = '0, rd_en = '0, flush = '0;
  logic [DW*NC-1:0] rd_data;
  logic [NC-1:0] rd_valid, full, empty, afull, aempty, ovf_err, udf_err;
  logic [CW*NC-1:0] count;
  typedef struct {logic [DW-1:0] d; int due;} exp_t;
  logic [DW-1:0] mq [NC][$];
  exp_t eq [NC][$];
  logic mo [NC], mu [NC];
  logic [DW-1:0] last [NC];
  int checks = 0, errors = 0, cyc = 0;
  fifo_mem_mc dut (
    .clk(clk), .reset_n(reset_n), .wr_data(wr_data), .wr_en(wr_en), .rd_en(rd_en),
    .flush(flush), .clr_err(clr_err), .rd_data(rd_data), .rd_valid(rd_valid), .count(count),
    .full(full), .empty(empty), .afull(afull), .aempty(aempty), .ovf_err(ovf_err), .udf_err(udf_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string nm, input int n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s ch%0d @cyc%0d: got %0d, expected %0d", nm, n, cyc, act, exp);
    end
  endtask
  // scoreboard monitor: every rd_valid pulse must match the oldest expected read
  always @(negedge clk) begin
    if (reset_n) begin
      for (int n = 0; n < NC; n++) begin
        if (rd_valid[n]) begin
          if (eq[n].size() == 0) chk("spurious_rd_valid", n, 1, 0);
          else begin
            exp_t e;
            e = eq[n].pop_front();
            chk("rd_data", n, int'(rd_data[DW*n +: DW]), int'(e.d));
            chk("rd_latency", n, cyc, e.due);
            last[n] = e.d;
          end
        end else begin
          chk("rd_data_hold", n, int'(rd_data[DW*n +: DW]), int'(last[n]));
          if (eq[n].size() > 0 && eq[n][0].due <= cyc) begin
            chk("rd_valid_missing", n, 0, 1);
            void'(eq[n].pop_front());
          end
        end
      end
    end
  end
  task automatic check_state();
    for (int n = 0; n < NC; n++) begin
      int sz;
      sz = mq[n].size();
      chk("count", n, int'(count[CW*n +: CW]), sz);
      chk("full", n, int'(full[n]), int'(sz == DEP));
      chk("empty", n, int'(empty[n]), int'(sz == 0));
      chk("afull", n, int'(afull[n]), int'(sz >= AF));
      chk("aempty", n, int'(aempty[n]), int'(sz <= AE));
      chk("ovf_err", n, int'(ovf_err[n]), int'(mo[n]));
      chk("udf_err", n, int'(udf_err[n]), int'(mu[n]));
    end
  endtask
  task automatic step(input logic [NC-1:0] we, input logic [NC-1:0] re, input logic [NC-1:0] fl,
                      input logic clr, input logic [DW-1:0] d);
    wr_en = we; rd_en = re; flush = fl; clr_err = clr; wr_data = d;
    for (int n = 0; n < NC; n++) begin
      logic ov, ud, rd, wr;
      int sz;
      exp_t e;
      ov = 1'b0; ud = 1'b0;
      sz = mq[n].size();
      if (fl[n]) mq[n].delete();
      else begin
        rd = re[n] && sz > 0;
        ud = re[n] && sz == 0;
        wr = we[n] && (sz < DEP || rd);
        ov = we[n] && !wr;
        if (rd) begin
          e.d = mq[n].pop_front();
          e.due = cyc + 1;
          eq[n].push_back(e);
        end
        if (wr) mq[n].push_back(d);
      end
      mo[n] = ov | (mo[n] & !clr);
      mu[n] = ud | (mu[n] & !clr);
    end
    @(posedge clk);
    #1;
    check_state();
  endtask
  task automatic model_clear();
    for (int n = 0; n < NC; n++) begin
      mq[n].delete(); eq[n].delete();
      mo[n] = 1'b0; mu[n] = 1'b0; last[n] = '0;
    end
  endtask
  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    wr_en = '0; rd_en = '0; flush = '0; clr_err = 1'b0;
    #1;
    for (int n = 0; n < NC; n++) begin
      chk("rst_count", n, int'(count[CW*n +: CW]), 0);
      chk("rst_empty", n, int'(empty[n]), 1);
      chk("rst_aempty", n, int'(aempty[n]), 1);
      chk("rst_full", n, int'(full[n] | afull[n]), 0);
      chk("rst_rd_valid", n, int'(rd_valid[n]), 0);
      chk("rst_rd_data", n, int'(rd_data[DW*n +: DW]), 0);
      chk("rst_errors", n, int'(ovf_err[n] | udf_err[n]), 0);
    end
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask
  function automatic logic [NC-1:0] oh(input int ch);
    return NC'(1) << ch;
  endfunction
  initial begin
    model_clear();
    @(posedge clk);
    #1;
    do_reset();
    check_state();
    // biased random traffic: write-heavy, read-heavy, then mixed with a mid-traffic reset
    for (int i = 0; i < 1800; i++) begin
      logic [NC-1:0] we, re, fl;
      we = i < 600 ? NC'($urandom | $urandom) : i < 1200 ? NC'($urandom & $urandom) : NC'($urandom);
      re = i < 600 ? NC'($urandom & $urandom) : i < 1200 ? NC'($urandom | $urandom) : NC'($urandom);
      fl = $urandom_range(0, 59) == 0 ? oh($urandom_range(0, NC - 1)) : '0;
      step(we, re, fl, $urandom_range(0, 39) == 0, DW'($urandom));
      if (i == 1500) do_reset();
    end
    step('0, '0, '1, 1'b1, '0);
    // ch0 ramp fill and drain
    for (int i = 0; i < DEP; i++) step(oh(0), '0, '0, 1'b0, DW'(i - 16384));
    for (int i = 0; i < DEP; i++) step('0, oh(0), '0, 1'b0, '0);
    // ch3 pointer wrap
    for (int i = 0; i < 200; i++) step(oh(3), '0, '0, 1'b0, DW'($urandom));
    for (int i = 0; i < 200; i++) step('0, oh(3), '0, 1'b0, '0);
    for (int i = 0; i < 100; i++) step(oh(3), '0, '0, 1'b0, DW'($urandom));
    for (int i = 0; i < 100; i++) step('0, oh(3), '0, 1'b0, '0);
    // ch1 full with simultaneous read/write, then empty with simultaneous read/write
    for (int i = 0; i < DEP; i++) step(oh(1), '0, '0, 1'b0, DW'($urandom));
    step(oh(1), oh(1), '0, 1'b0, 16'h7abc);
    for (int i = 0; i < DEP; i++) step('0, oh(1), '0, 1'b0, '0);
    step(oh(1), oh(1), '0, 1'b0, 16'h8001);
    step('0, oh(1), '0, 1'b1, '0);
    // ch2 overflow, clear, and clear colliding with a new overflow
    for (int i = 0; i < DEP; i++) step(oh(2), '0, '0, 1'b0, DW'($urandom));
    step(oh(2), '0, '0, 1'b0, 16'hdead);
    step('0, '0, '0, 1'b1, '0);
    step(oh(2), '0, '0, 1'b1, 16'hbeef);
    for (int i = 0; i < DEP; i++) step('0, oh(2), '0, 1'b0, '0);
    // ch5 flush with colliding read/write while ch4 streams
    for (int i = 0; i < 10; i++) step(oh(5) | (NC'($urandom) & oh(4)), NC'($urandom) & oh(4), '0, 1'b0, DW'($urandom));
    step(oh(5) | oh(4), oh(5) | (NC'($urandom) & oh(4)), oh(5), 1'b0, DW'($urandom));
    for (int i = 0; i < 30; i++) step(NC'($urandom) & oh(4), NC'($urandom) & oh(4), '0, 1'b0, DW'($urandom));
    for (int i = 0; i < 4; i++) step('0, '0, '0, 1'b0, '0);
    for (int n = 0; n < NC; n++) chk("pending_reads", n, eq[n].size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
